// File: rtl/draw_cmd_sequencer_if.sv
// Draw command channel: valid/ready handshake carrying one clear or circle command.
interface draw_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_centre_x;
  logic [6:0] cmd_centre_y;
  logic [7:0] cmd_radius;
  logic [2:0] cmd_colour;

  modport master (
    output cmd_valid, cmd_op, cmd_centre_x, cmd_centre_y, cmd_radius, cmd_colour,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_centre_x, cmd_centre_y, cmd_radius, cmd_colour,
    output cmd_ready
  );
endinterface

// File: rtl/draw_cmd_sequencer.sv
// Queues draw commands, runs fillscreen/circle engines one at a time and grants them the VGA port.
// Optional macro DRAW_SEQ_PLOT_CLIP_EN drops granted plots outside SCREEN_W x SCREEN_H.
module draw_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input  logic                clk,
  input  logic                rst_n,
  draw_cmd_sequencer_if.slave cmd,
  output logic                fill_start,
  input  logic                fill_done,
  output logic [2:0]          fill_colour,
  input  logic [7:0]          fill_x,
  input  logic [6:0]          fill_y,
  input  logic [2:0]          fill_vcolour,
  input  logic                fill_plot,
  output logic                circ_start,
  input  logic                circ_done,
  output logic [7:0]          circ_centre_x,
  output logic [6:0]          circ_centre_y,
  output logic [7:0]          circ_radius,
  output logic [2:0]          circ_colour,
  input  logic [7:0]          circ_x,
  input  logic [6:0]          circ_y,
  input  logic [2:0]          circ_vcolour,
  input  logic                circ_plot,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [2:0]          vga_colour,
  output logic                vga_plot,
  output logic                busy
);
  localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  if (CMD_DEPTH < 2 || CMD_DEPTH > 16 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      SCREEN_W == 0 || SCREEN_W > 256 || SCREEN_H == 0 || SCREEN_H > 128) begin : g_bad_params
    $error("draw_cmd_sequencer: illegal parameter values");
  end

  typedef struct packed {
    logic       op;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] r;
    logic [2:0] colour;
  } cmd_t;

  typedef enum logic [2:0] {StIdle, StStart, StWaitDone, StRelease, StWaitLow} state_t;

  cmd_t            mem [CMD_DEPTH];
  cmd_t            head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q;
  logic            push, pop;
  state_t          state_q;
  logic            owner_q;  // 0 = fillscreen, 1 = circle
  logic            owner_done;
  logic            grant;
  logic [7:0]      sel_x;
  logic [6:0]      sel_y;
  logic [2:0]      sel_colour;
  logic            sel_plot;
  logic            on_screen;

  assign push          = cmd.cmd_valid & ready_q;
  assign pop           = (state_q == StIdle) && (count_q != '0);
  assign cmd.cmd_ready = ready_q;
  assign head          = mem[rd_ptr_q];
  assign busy          = (count_q != '0) | (state_q != StIdle);

  always_comb begin
    count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{op: cmd.cmd_op, cx: cmd.cmd_centre_x, cy: cmd.cmd_centre_y,
                         r: cmd.cmd_radius, colour: cmd.cmd_colour};
    end
  end

  // ready is registered so it stays low while reset is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CntW'(CMD_DEPTH));
    end
  end

  assign owner_done = owner_q ? circ_done    : fill_done;
  assign grant      = (state_q == StStart) || (state_q == StWaitDone);
  assign sel_x      = owner_q ? circ_x       : fill_x;
  assign sel_y      = owner_q ? circ_y       : fill_y;
  assign sel_colour = owner_q ? circ_vcolour : fill_vcolour;
  assign sel_plot   = owner_q ? circ_plot    : fill_plot;

`ifdef DRAW_SEQ_PLOT_CLIP_EN
  assign on_screen = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);
`else
  assign on_screen = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      fill_start    <= 1'b0;
      circ_start    <= 1'b0;
      fill_colour   <= '0;
      circ_centre_x <= '0;
      circ_centre_y <= '0;
      circ_radius   <= '0;
      circ_colour   <= '0;
      vga_x         <= '0;
      vga_y         <= '0;
      vga_colour    <= '0;
      vga_plot      <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      if (grant) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_colour;
        vga_plot   <= sel_plot & on_screen;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            owner_q <= head.op;
            if (head.op) begin
              circ_centre_x <= head.cx;
              circ_centre_y <= head.cy;
              circ_radius   <= head.r;
              circ_colour   <= head.colour;
            end else begin
              fill_colour <= head.colour;
            end
            state_q <= StStart;
          end
        end
        StStart: begin
          fill_start <= ~owner_q;
          circ_start <= owner_q;
          state_q    <= StWaitDone;
        end
        StWaitDone: begin
          if (owner_done) begin
            fill_start <= 1'b0;
            circ_start <= 1'b0;
            state_q    <= StRelease;
          end
        end
        StRelease: state_q <= StWaitLow;
        // engine must drop done before the next start can be issued
        StWaitLow: if (!owner_done) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Directed bench for draw_cmd_sequencer: plot vector tables plus hand-written sequences.
module tb_draw_cmd_sequencer;
`ifdef DRAW_SEQ_PLOT_CLIP_EN
  localparam bit Clip = 1'b1;
`else
  localparam bit Clip = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fill_start, fill_done, fill_plot, circ_start, circ_done, circ_plot, vga_plot, busy;
  logic [2:0] fill_colour, fill_vcolour, circ_colour, circ_vcolour, vga_colour;
  logic [7:0] fill_x, circ_x, circ_centre_x, circ_radius, vga_x;
  logic [6:0] fill_y, circ_y, circ_centre_y, vga_y;

  int checks = 0;
  int failures = 0;

  draw_cmd_sequencer_if cmd_if ();

  draw_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
    .fill_start(fill_start), .fill_done(fill_done), .fill_colour(fill_colour),
    .fill_x(fill_x), .fill_y(fill_y), .fill_vcolour(fill_vcolour), .fill_plot(fill_plot),
    .circ_start(circ_start), .circ_done(circ_done), .circ_centre_x(circ_centre_x),
    .circ_centre_y(circ_centre_y), .circ_radius(circ_radius), .circ_colour(circ_colour),
    .circ_x(circ_x), .circ_y(circ_y), .circ_vcolour(circ_vcolour), .circ_plot(circ_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] fx; logic [6:0] fy; logic [2:0] fc; logic fp;
    logic [7:0] cx; logic [6:0] cy; logic [2:0] cc; logic cp;
    logic [7:0] ex; logic [6:0] ey; logic [2:0] ec; logic ep;
  } vec_t;

  vec_t fill_vecs [2];
  vec_t circ_vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int idx);
    fill_x = v.fx; fill_y = v.fy; fill_vcolour = v.fc; fill_plot = v.fp;
    circ_x = v.cx; circ_y = v.cy; circ_vcolour = v.cc; circ_plot = v.cp;
    step();
    check($sformatf("%s%0d_x", tag, idx), vga_x, v.ex);
    check($sformatf("%s%0d_y", tag, idx), vga_y, v.ey);
    check($sformatf("%s%0d_colour", tag, idx), vga_colour, v.ec);
    check($sformatf("%s%0d_plot", tag, idx), vga_plot, v.ep);
    fill_plot = 1'b0;
    circ_plot = 1'b0;
  endtask

  task automatic push_cmd(input logic op, input logic [7:0] cx, input logic [6:0] cy,
                          input logic [7:0] r, input logic [2:0] col);
    int n = 0;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op; cmd_if.cmd_centre_x = cx;
    cmd_if.cmd_centre_y = cy; cmd_if.cmd_radius = r; cmd_if.cmd_colour = col;
    while (!cmd_if.cmd_ready && n < 50) begin step(); n++; end
    if (n >= 50) check("push_timeout", 0, 1);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (!fill_start && !circ_start && n < 50) begin step(); n++; end
    check({nm, "_start_seen"}, (n < 50), 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 50) begin step(); n++; end
    check({nm, "_idle"}, busy, 0);
  endtask

  // Runs the engine that currently holds start; checks op and its key operand.
  task automatic serve(input logic op, input logic [7:0] val, input string nm);
    wait_start(nm);
    check({nm, "_which"}, {fill_start, circ_start}, op ? 2'b01 : 2'b10);
    check({nm, "_operand"}, op ? circ_radius : {5'b0, fill_colour}, val);
    if (op) circ_done = 1'b1; else fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    circ_done = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_vecs[0] = '{8'd5, 7'd6, 3'd3, 1'b1, 8'd9, 7'd9, 3'd7, 1'b1, 8'd5, 7'd6, 3'd3, 1'b1};
    fill_vecs[1] = '{8'd255, 7'd127, 3'd0, 1'b0, 8'd1, 7'd1, 3'd1, 1'b1,
                     8'd255, 7'd127, 3'd0, 1'b0};
    circ_vecs[0] = '{8'd1, 7'd2, 3'd7, 1'b1, 8'd10, 7'd20, 3'd5, 1'b0, 8'd10, 7'd20, 3'd5, 1'b0};
    circ_vecs[1] = '{8'd3, 7'd3, 3'd1, 1'b1, 8'd10, 7'd20, 3'd5, 1'b1, 8'd10, 7'd20, 3'd5, 1'b1};
    circ_vecs[2] = '{8'd0, 7'd0, 3'd0, 1'b0, 8'd200, 7'd10, 3'd4, 1'b1,
                     8'd200, 7'd10, 3'd4, ~Clip};
    circ_vecs[3] = '{8'd0, 7'd0, 3'd0, 1'b1, 8'd159, 7'd119, 3'd6, 1'b1,
                     8'd159, 7'd119, 3'd6, 1'b1};
    circ_vecs[4] = '{8'd0, 7'd0, 3'd0, 1'b0, 8'd160, 7'd5, 3'd1, 1'b1, 8'd160, 7'd5, 3'd1, ~Clip};
    circ_vecs[5] = '{8'd0, 7'd0, 3'd0, 1'b0, 8'd0, 7'd120, 3'd2, 1'b1, 8'd0, 7'd120, 3'd2, ~Clip};

    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 1'b0; cmd_if.cmd_centre_x = '0;
    cmd_if.cmd_centre_y = '0; cmd_if.cmd_radius = '0; cmd_if.cmd_colour = '0;
    fill_done = 1'b0; fill_x = '0; fill_y = '0; fill_vcolour = '0; fill_plot = 1'b0;
    circ_done = 1'b0; circ_x = '0; circ_y = '0; circ_vcolour = '0; circ_plot = 1'b0;

    // Reset state
    step(); step();
    check("rst_ready", cmd_if.cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_starts", {fill_start, circ_start}, 0);
    check("rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
    #2 rst_n = 1'b1;
    step();
    check("ready_after_rst", cmd_if.cmd_ready, 1);

    // Single clear: start rises two edges after the push edge
    push_cmd(1'b0, 8'd0, 7'd0, 8'd0, 3'd0);
    check("clr_busy", busy, 1);
    check("clr_start_e0", fill_start, 0);
    step();
    check("clr_start_e1", fill_start, 0);
    step();
    check("clr_start_e2", fill_start, 1);
    check("clr_colour", fill_colour, 0);
    step();
    check("clr_start_hold", fill_start, 1);
    fill_done = 1'b1;
    step();
    check("clr_start_fall", fill_start, 0);
    step(); step(); step();
    check("clr_busy_done_high", busy, 1);
    fill_done = 1'b0;
    step();
    check("clr_idle_after_done_low", busy, 0);

    // Clear then circle back-to-back; plot ownership
    push_cmd(1'b0, 8'd0, 7'd0, 8'd0, 3'd3);
    push_cmd(1'b1, 8'd80, 7'd60, 8'd30, 3'd2);
    wait_start("b2b_clr");
    check("b2b_fill_first", {fill_start, circ_start}, 2'b10);
    check("b2b_fill_colour", fill_colour, 3);
    for (int i = 0; i < 2; i++) apply_vec(fill_vecs[i], "fvec", i);
    fill_done = 1'b1;
    step();
    check("b2b_fill_fall", fill_start, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("b2b_circ_held%0d", i), circ_start, 0);
    end
    fill_done = 1'b0;
    wait_start("b2b_circ");
    check("b2b_circ_start", {fill_start, circ_start}, 2'b01);
    check("b2b_circ_ops", {circ_centre_x, circ_centre_y, circ_radius, circ_colour},
          {8'd80, 7'd60, 8'd30, 3'd2});
    for (int i = 0; i < 6; i++) apply_vec(circ_vecs[i], "cvec", i);
    circ_done = 1'b1;
    step();
    check("b2b_circ_fall", circ_start, 0);
    step();
    check("b2b_release_plot", vga_plot, 0);
    check("b2b_vga_hold", {vga_x, vga_y}, {8'd0, 7'd120});
    check("b2b_ops_stable", {circ_centre_x, circ_centre_y, circ_radius, circ_colour},
          {8'd80, 7'd60, 8'd30, 3'd2});
    circ_done = 1'b0;
    wait_idle("b2b");

    // FIFO full while the circle engine is stalled
    push_cmd(1'b1, 8'd1, 7'd1, 8'd99, 3'd1);
    wait_start("full_stall");
    push_cmd(1'b0, 8'd0, 7'd0, 8'd0, 3'd1);
    push_cmd(1'b1, 8'd2, 7'd2, 8'd11, 3'd4);
    push_cmd(1'b0, 8'd0, 7'd0, 8'd0, 3'd2);
    push_cmd(1'b1, 8'd3, 7'd3, 8'd12, 3'd6);
    check("full_ready_low", cmd_if.cmd_ready, 0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 1'b0; cmd_if.cmd_colour = 3'd5;
    step(); step();
    check("full_ready_stalled", cmd_if.cmd_ready, 0);
    circ_done = 1'b1;
    step();
    circ_done = 1'b0;
    check("full_ready_release", cmd_if.cmd_ready, 0);
    step(); step();
    check("full_ready_idle", cmd_if.cmd_ready, 0);
    step();
    check("full_ready_after_pop", cmd_if.cmd_ready, 1);
    step();
    cmd_if.cmd_valid = 1'b0;
    check("full_fifth_accepted", cmd_if.cmd_ready, 0);
    serve(1'b0, 8'd1, "ord0");
    serve(1'b1, 8'd11, "ord1");
    serve(1'b0, 8'd2, "ord2");
    serve(1'b1, 8'd12, "ord3");
    serve(1'b0, 8'd5, "ord4");
    wait_idle("ord");
    check("ord_ready", cmd_if.cmd_ready, 1);

    // Asynchronous reset during WAIT_DONE discards queued work
    push_cmd(1'b1, 8'd40, 7'd40, 8'd7, 3'd3);
    wait_start("arst");
    push_cmd(1'b0, 8'd0, 7'd0, 8'd0, 3'd4);
    circ_x = 8'd10; circ_y = 7'd20; circ_vcolour = 3'd5; circ_plot = 1'b1;
    step();
    check("arst_plot_before", vga_plot, 1);
    check("arst_start_before", circ_start, 1);
    rst_n = 1'b0;
    #1;
    check("arst_start_async", circ_start, 0);
    check("arst_plot_async", vga_plot, 0);
    check("arst_busy_async", busy, 0);
    circ_plot = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    check("arst_busy_after", busy, 0);
    check("arst_ready_after", cmd_if.cmd_ready, 1);
    step(); step(); step();
    check("arst_fifo_discarded", {fill_start, circ_start, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/draw_cmd_sequencer.md
Name: draw_cmd_sequencer

Overview:
- Front-end controller for the lab drawing engines: accepts queued draw commands (clear-screen, circle) over a valid/ready interface.
- Sequences the fillscreen and circle engines one at a time using their start/done protocol.
- Grants the single VGA adapter plot port to whichever engine is active.
- Sits between the top-level command source (switches/test sequence) and the fillscreen, circle and VGA adapter instances.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, 2..16.
- SCREEN_W, 160, visible width in pixels (used only by the optional clip feature).
- SCREEN_H, 120, visible height in pixels (used only by the optional clip feature).

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  1  0 = clear screen, 1 = circle
- cmd_centre_x  in  8  circle centre x
- cmd_centre_y  in  7  circle centre y
- cmd_radius  in  8  circle radius
- cmd_colour  in  3  colour for both ops
- fill_start  out  1  fillscreen start
- fill_done  in  1  fillscreen done
- fill_colour  out  3  fillscreen colour operand
- fill_x / fill_y / fill_vcolour / fill_plot  in  8/7/3/1  fillscreen plot request
- circ_start  out  1  circle start
- circ_done  in  1  circle done
- circ_centre_x / circ_centre_y / circ_radius / circ_colour  out  8/7/8/3  circle operands
- circ_x / circ_y / circ_vcolour / circ_plot  in  8/7/3/1  circle plot request
- vga_x / vga_y / vga_colour / vga_plot  out  8/7/3/1  to VGA adapter
- busy  out  1  FIFO non-empty or engine active

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0. FIFO is empty, state is IDLE, cmd_ready=1 from the first clock edge after reset deasserts.
- FIFO:
  - A push occurs on cmd_valid & cmd_ready.
  - cmd_ready = !full.
  - Pointers wrap modulo CMD_DEPTH. A count register is used so that full and empty are distinguished.
  - Push and pop in the same cycle are legal when the FIFO is non-empty and not full; count is unchanged.
  - A command pushed into an empty FIFO at edge N is popped at edge N+1 at the earliest. There is no bypass.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the operand registers, latch owner = op, go to START.
  - START: assert the owner's start; hold operands stable; go to WAIT_DONE.
  - WAIT_DONE: hold start high until the owner's done=1, then go to RELEASE.
  - RELEASE: deassert start; go to WAIT_LOW.
  - WAIT_LOW: remain until the owner's done=0, then go to IDLE. A new start is never issued while the previous done is still high.
- Operand outputs (fill_colour, circ_*) are registered and change only on a pop. They are stable for the entire START..WAIT_LOW window.
- Engine start outputs and sampling:
  - The non-owner's start is always 0.
  - The non-owner's done is ignored in all states.
  - done is ignored in IDLE.
- Plot arbitration:
  - In START and WAIT_DONE, the owner's x/y/vcolour/plot are registered onto vga_* with 1-cycle latency.
  - In all other states, vga_plot=0 and vga_x/y/colour hold their last value.
  - A non-owner plot is dropped silently.
- busy = (count != 0) | (state != IDLE).
- Widths: all pass-through fields are identical widths; no arithmetic beyond the FIFO pointers and count.
- Reset mid-operation: starts drop to 0 asynchronously and vga_plot drops to 0; FIFO contents are discarded. Engines are reset by the same rst_n.

Optional Feature:
- Macro: DRAW_SEQ_PLOT_CLIP_EN.
- Defined: vga_plot is forced to 0 for any granted plot with x >= SCREEN_W or y >= SCREEN_H. This suppresses off-screen circle octant pixels; vga_x/y still update.
- Undefined: granted plots pass through unfiltered; the SCREEN_W/SCREEN_H parameters are unused.

Test Plan:
- Reset, then push clear(colour=0) → fill_start rises 2 cycles after the push edge; fill_colour=0; after fill_done, fill_start falls the next cycle; state reaches IDLE only after fill_done=0.
- Push clear(0) then circle(x=80,y=60,r=30,colour=2) back-to-back → circ_start stays 0 until fill_done has fallen; circ operands are 80/60/30/2 and stable until circ_done falls; only fill plots appear during clear, only circ plots during circle.
- Push 5 commands with CMD_DEPTH=4 while an engine is stalled (done held 0) → cmd_ready=0 after the 4th accepted command; the 5th waits and is accepted the cycle after the first pop; execution order is preserved.
- Toggle fill_plot while the circle engine owns the port → vga_plot never reflects fill_plot; a circ_plot at (10,20,c=5) appears on vga_* one cycle later.
- With DRAW_SEQ_PLOT_CLIP_EN: circ_plot at (200,10) gives vga_plot=0, and at (159,119) gives vga_plot=1. Without the macro, both give vga_plot=1.
- Assert rst_n=0 during WAIT_DONE → circ_start and vga_plot are 0 immediately (asynchronously); after release, busy=0 and cmd_ready=1.
